// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module  : pc_seq_pkg
// Purpose : Shared types and constants for the PC sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    TRAP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE          = 2'd0,
    FETCH_TIMEOUT = 2'd1,
    MISALIGNED    = 2'd2
  } trap_cause_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  function automatic logic is_word_aligned(input logic [1:0] i_low_bits);
    return (i_low_bits == 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module  : pc_sequencer
// Purpose : Sequences PcNext, runs the imem fetch handshake with timeout and
//           presents one instruction at a time to the datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR    = 32'h0000_0100,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_pc,
  output logic [31:0] o_pc_next,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  input  logic        i_core_ready,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_target,
  output logic        o_trap_valid,
  output logic [1:0]  o_trap_cause,
  output logic [31:0] o_instret
);

  localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  trap_cause_t r_cause;
  trap_cause_t w_cause_nxt;
  logic [7:0]  r_tmo_cnt;
  logic [31:0] r_instr;
  logic [31:0] r_instret;

  logic w_fetch_done;
  logic w_timeout;
  logic w_commit;
  logic w_target_ok;
  logic w_misalign;

  assign w_fetch_done = (r_state == FETCH) && i_imem_ready;
  // Ready wins over an expiring counter in the same cycle.
  assign w_timeout    = (r_state == FETCH) && !i_imem_ready && (r_tmo_cnt == c_TMO_LAST);
  assign w_commit     = (r_state == HOLD) && i_core_ready;
  assign w_target_ok  = is_word_aligned(i_redirect_target[1:0]);
  assign w_misalign   = w_commit && i_redirect_valid && !w_target_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = NONE;
    case (r_state)
      IDLE: begin
        w_state_nxt = FETCH;
      end
      FETCH: begin
        if (i_imem_ready) begin
          w_state_nxt = HOLD;
        end else if (w_timeout) begin
          w_state_nxt = TRAP;
          w_cause_nxt = FETCH_TIMEOUT;
        end
      end
      HOLD: begin
        if (w_misalign) begin
          w_state_nxt = TRAP;
          w_cause_nxt = MISALIGNED;
        end else if (w_commit) begin
          w_state_nxt = FETCH;
        end
      end
      TRAP: begin
        w_state_nxt = FETCH;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    o_pc_next     = i_pc;
    o_imem_req    = 1'b0;
    o_instr_valid = 1'b0;
    o_trap_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        o_pc_next = RESET_VECTOR;
      end
      FETCH: begin
        o_imem_req = 1'b1;
      end
      HOLD: begin
        o_instr_valid = 1'b1;
        if (w_commit && !i_redirect_valid) begin
          o_pc_next = i_pc + INSTR_BYTES;
        end else if (w_commit && w_target_ok) begin
          o_pc_next = i_redirect_target;
        end
      end
      TRAP: begin
        o_trap_valid = 1'b1;
        o_pc_next    = TRAP_VECTOR;
      end
      default: begin
        o_pc_next = RESET_VECTOR;
      end
    endcase
  end

  // The counter is only non-zero while a fetch is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= 8'd0;
      r_instr   <= 32'd0;
      r_instret <= 32'd0;
      r_cause   <= NONE;
    end else begin
      r_cause <= w_cause_nxt;
      if ((r_state == FETCH) && !i_imem_ready && !w_timeout) begin
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end else begin
        r_tmo_cnt <= 8'd0;
      end
      if (w_fetch_done) begin
        r_instr <= i_imem_rdata;
      end
      if (w_commit && !w_misalign) begin
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  assign o_imem_addr  = i_pc;
  assign o_instr      = r_instr;
  assign o_instret    = r_instret;
  assign o_trap_cause = (r_state == TRAP) ? r_cause : NONE;

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller that sequences the ProgramCounter register of the single-cycle core.
- Drives PcNext: hold, advance by 4, redirect to a branch/jump target, or vector to the trap handler.
- Runs the instruction-memory fetch handshake with a wait-state timeout, and presents one instruction at a time to the datapath.
- Sits between ProgramCounter, instruction memory and the datapath control unit.

Parameters:
RESET_VECTOR, 32'h0000_0000, pc_next value during and after reset; must match ProgramCounter reset value
TRAP_VECTOR, 32'h0000_0100, pc_next on any fetch trap
TIMEOUT_CYCLES, 16, max FETCH cycles without imem_ready before a fetch-fault trap (range 2..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
pc  in  32  current PC from ProgramCounter
pc_next  out  32  next PC to ProgramCounter
imem_req  out  1  fetch request
imem_addr  out  32  fetch address
imem_ready  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  fetched word
instr  out  32  registered instruction to datapath
instr_valid  out  1  instr holds a valid instruction
core_ready  in  1  datapath commits instr this cycle
redirect_valid  in  1  committed instr is a taken branch or jump
redirect_target  in  32  branch/jump target
trap_valid  out  1  one-cycle trap pulse
trap_cause  out  2  0=none, 1=fetch timeout, 2=misaligned target
instret  out  32  retired-instruction count, wraps

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE; counters cleared.
  - pc_next=RESET_VECTOR; instr=0; all valid/req outputs 0; trap_cause=0; instret=0.
  - imem_req drops immediately, even mid-fetch.
- pc_next is combinational from state and inputs; ProgramCounter loads it every edge. "Hold" means pc_next=pc.
- States IDLE, FETCH, HOLD, TRAP:
- IDLE:
  - pc_next=RESET_VECTOR.
  - Goes to FETCH on the next edge after reset deasserts.
- FETCH:
  - imem_req=1, imem_addr=pc, pc_next=pc.
  - Timeout counter increments each cycle without imem_ready.
  - imem_ready=1: instr<=imem_rdata, counter<=0, go HOLD.
  - Counter reaching TIMEOUT_CYCLES-1 without ready: go TRAP, cause 1.
  - imem_ready takes priority over timeout in the same cycle.
- HOLD:
  - instr_valid=1, imem_req=0.
  - core_ready=0: pc_next=pc, instr stable.
  - core_ready=1, redirect_valid=0: pc_next=pc+4 (mod 2^32, wraps silently), instret+1, go FETCH.
  - core_ready=1, redirect_valid=1, redirect_target[1:0]==0: pc_next=redirect_target, instret+1, go FETCH.
  - core_ready=1, redirect_valid=1, redirect_target[1:0]!=0: pc_next=pc, instret unchanged, go TRAP, cause 2.
  - redirect_valid is ignored while core_ready=0.
- TRAP (one cycle):
  - trap_valid=1 with the latched cause; pc_next=TRAP_VECTOR; instr_valid=0.
  - Any imem_ready this cycle is ignored.
  - Go FETCH; trap_cause returns to 0 when trap_valid falls.
- Latency:
  - Zero-wait memory gives 2 cycles per instruction: FETCH cycle, then HOLD with core_ready=1.
  - Each memory wait state adds 1 cycle.
- instr_valid and imem_req are never high together.
- imem_addr is always the registered pc; no combinational path from imem_ready to imem_req.

Decomposition:
- Package pc_seq_pkg holds:
  - state_t enum (IDLE, FETCH, HOLD, TRAP).
  - trap_cause_t enum (NONE=0, FETCH_TIMEOUT=1, MISALIGNED=2).
  - Constant INSTR_BYTES=4.
- No sub-module needed. The timeout counter is an 8-bit register inside pc_sequencer.
- The top-level test harness instantiates pc_sequencer together with ProgramCounter.

Test Plan:
- Reset release, zero-wait memory, core_ready=1 constantly -> pc sequence 0,4,8,12 every 2 cycles; instret=3 after the third commit.
- imem_ready delayed 3 cycles -> imem_req high for 4 consecutive cycles, imem_addr stable; instr_valid rises the cycle after ready.
- HOLD with core_ready=0 for 5 cycles, then 1 with redirect_target=0x40 -> pc_next=pc for 5 cycles, then pc=0x40; next fetch addr 0x40.
- redirect_target=0x42 -> trap_valid 1 cycle, trap_cause=2; next fetch addr 0x100; instret not incremented.
- imem_ready never asserted -> trap after 16 FETCH cycles, cause 1, pc=0x100; with ready on cycle 16 -> no trap.
- reset low mid-FETCH -> imem_req=0 the same cycle, pc_next=0, instret=0; fetch resumes at 0 after release.
